// File: rtl/pio_evt_pkg.sv
// pio_evt_pkg -- shared definitions for the PIO event master.
//   PIO register map (DATA / MASK / EDGE), the service FSM state type and
//   small helpers that build Avalon-MM initiator commands.
package pio_evt_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    localparam int TS_W = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_EDGE,
        ST_WT_EDGE,
        ST_RD_DATA,
        ST_WT_DATA,
        ST_CLR,
        ST_PUSH
    } pio_state_e;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [1:0]  address;
        logic [31:0] writedata;
    } avm_cmd_t;

    function automatic avm_cmd_t avm_idle();
        avm_cmd_t c;
        c.cs        = 1'b0;
        c.write_n   = 1'b1;
        c.address   = PIO_ADDR_DATA;
        c.writedata = 32'd0;
        return c;
    endfunction

    function automatic avm_cmd_t avm_read(input logic [1:0] addr);
        avm_cmd_t c;
        c.cs        = 1'b1;
        c.write_n   = 1'b1;
        c.address   = addr;
        c.writedata = 32'd0;
        return c;
    endfunction

    function automatic avm_cmd_t avm_write(input logic [1:0] addr, input logic [31:0] data);
        avm_cmd_t c;
        c.cs        = 1'b1;
        c.write_n   = 1'b0;
        c.address   = addr;
        c.writedata = data;
        return c;
    endfunction

endpackage

// File: rtl/pio_evt_fifo.sv
// pio_evt_fifo -- first-word-fall-through event queue.
//   clk, reset      : clock, synchronous active-high reset (empties the queue)
//   push, din       : write request and data (ignored when full unless popping)
//   pop             : read request (ignored when empty)
//   dout            : head entry, valid whenever empty=0
//   full, empty     : occupancy flags
// A push and a pop in the same cycle on a full queue both succeed.
module pio_evt_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pio_event_master.sv
// pio_event_master -- services a PIO edge-capture interrupt and queues events.
//   clk, reset            : clock, synchronous active-high reset
//   irq                   : PIO interrupt
//   avm_*                 : Avalon-MM initiator to the PIO (no waitrequest,
//                           readdata registered, valid one cycle after address)
//   evt_valid/evt_ready   : FWFT event queue handshake
//   evt_edges, evt_level  : captured edge bits and input level of head event
//   evt_time              : cycle stamp of head event (PIO_EVT_TIMESTAMP_EN only)
//   drop_count            : events discarded on a full queue, saturates at 255
// Optional feature macro: PIO_EVT_TIMESTAMP_EN adds a free-running 16-bit
// cycle counter sampled in RD_EDGE and stored with each queue entry.
//
// state    | meaning
// ---------+----------------------------------------------------------
// INIT     | write IRQ_MASK to PIO mask register (once after reset)
// IDLE     | bus idle, wait for irq
// RD_EDGE  | read PIO edge-capture register
// WT_EDGE  | latch edge bits; zero means spurious irq -> IDLE
// RD_DATA  | read PIO data register
// WT_DATA  | latch input level
// CLR      | write latched edge bits back to clear exactly those bits
// PUSH     | enqueue {edge, level}, or count a drop when full
module pio_event_master
    import pio_evt_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK   = 4'hF,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    input  logic [31:0]      avm_readdata,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
`ifdef PIO_EVT_TIMESTAMP_EN
    output logic [TS_W-1:0]  evt_time,
`endif
    output logic [7:0]       drop_count
);

`ifdef PIO_EVT_TIMESTAMP_EN
    localparam int QW = 2*WIDTH + TS_W;
`else
    localparam int QW = 2*WIDTH;
`endif

    pio_state_e       state_q, state_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] level_cap_q, level_cap_d;
    logic [7:0]       drop_q, drop_d;
    avm_cmd_t         cmd;
    logic             fifo_push, fifo_full, fifo_empty;
    logic [QW-1:0]    fifo_din, fifo_dout;
    logic             unused_rd_hi;

    assign unused_rd_hi = ^avm_readdata[31:WIDTH];

    always_comb begin
        state_d     = state_q;
        edge_cap_d  = edge_cap_q;
        level_cap_d = level_cap_q;
        drop_d      = drop_q;
        cmd         = avm_idle();
        fifo_push   = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                cmd     = avm_write(PIO_ADDR_MASK, 32'(IRQ_MASK));
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (irq) state_d = ST_RD_EDGE;
            end
            ST_RD_EDGE: begin
                cmd     = avm_read(PIO_ADDR_EDGE);
                state_d = ST_WT_EDGE;
            end
            ST_WT_EDGE: begin
                edge_cap_d = avm_readdata[WIDTH-1:0];
                state_d    = (avm_readdata[WIDTH-1:0] == '0) ? ST_IDLE : ST_RD_DATA;
            end
            ST_RD_DATA: begin
                cmd     = avm_read(PIO_ADDR_DATA);
                state_d = ST_WT_DATA;
            end
            ST_WT_DATA: begin
                level_cap_d = avm_readdata[WIDTH-1:0];
                state_d     = ST_CLR;
            end
            ST_CLR: begin
                cmd     = avm_write(PIO_ADDR_EDGE, 32'(edge_cap_q));
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                fifo_push = 1'b1;
                // A full queue with a simultaneous pop still accepts the push.
                if (fifo_full && !evt_ready && drop_q != 8'hFF)
                    drop_d = drop_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            edge_cap_q  <= '0;
            level_cap_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            edge_cap_q  <= edge_cap_d;
            level_cap_q <= level_cap_d;
            drop_q      <= drop_d;
        end
    end

    // The bus is held idle while reset is asserted, so the INIT mask write
    // shows up exactly once, in the first cycle after reset is released.
    assign avm_chipselect = cmd.cs & ~reset;
    assign avm_write_n    = cmd.write_n | reset;
    assign avm_address    = reset ? PIO_ADDR_DATA : cmd.address;
    assign avm_writedata  = reset ? 32'd0 : cmd.writedata;

`ifdef PIO_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] ts_cap_q, ts_cap_d;

    always_comb begin
        ts_d     = ts_q + 16'd1;
        ts_cap_d = (state_q == ST_RD_EDGE) ? ts_q : ts_cap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            ts_cap_q <= '0;
        end else begin
            ts_q     <= ts_d;
            ts_cap_q <= ts_cap_d;
        end
    end

    assign fifo_din = {ts_cap_q, edge_cap_q, level_cap_q};
    assign {evt_time, evt_edges, evt_level} = fifo_dout;
`else
    assign fifo_din = {edge_cap_q, level_cap_q};
    assign {evt_edges, evt_level} = fifo_dout;
`endif

    pio_evt_fifo #(
        .DW    (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (evt_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid  = ~fifo_empty;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pio_event_master.sv
// Bench for pio_event_master: a PIO device model (falling-edge capture,
// bit-clear on edge write, registered readdata with random filler otherwise)
// drives the DUT; a transaction-timeline model predicts bus traffic and queue
// contents; directed scenarios add hand-computed literal expectations.
module tb_pio_event_master;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         irq;
    logic [31:0]  avm_readdata = 32'd0;
    logic [1:0]   avm_address;
    logic         avm_chipselect, avm_write_n;
    logic [31:0]  avm_writedata;
    logic         evt_valid;
    logic         evt_ready = 1'b0;
    logic [W-1:0] evt_edges, evt_level;
    logic [7:0]   drop_count;
`ifdef PIO_EVT_TIMESTAMP_EN
    logic [15:0]  evt_time;
`endif

    pio_event_master #(.WIDTH(W), .IRQ_MASK(4'hF), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .irq            (irq),
        .avm_readdata   (avm_readdata),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_level      (evt_level),
`ifdef PIO_EVT_TIMESTAMP_EN
        .evt_time       (evt_time),
`endif
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- PIO device model ----------------
    logic [W-1:0] pio_in = 4'hF;
    logic [W-1:0] pio_prev = 4'hF;
    logic [W-1:0] pio_edge = 4'h0;
    logic [W-1:0] pio_mask = 4'h0;
    logic         irq_force = 1'b0;

    assign irq = (|(pio_edge & pio_mask)) | irq_force;

    always @(posedge clk) begin
        logic [W-1:0] clr;
        clr = (avm_chipselect && !avm_write_n && avm_address == 2'd3) ? avm_writedata[W-1:0] : '0;
        pio_prev <= pio_in;
        pio_edge <= (pio_edge & ~clr) | (pio_prev & ~pio_in);
        if (avm_chipselect && !avm_write_n && avm_address == 2'd2) pio_mask <= avm_writedata[W-1:0];
        if (avm_chipselect && avm_write_n) begin
            case (avm_address)
                2'd0:    avm_readdata <= {28'($urandom), pio_in};
                2'd2:    avm_readdata <= {28'($urandom), pio_mask};
                2'd3:    avm_readdata <= {28'($urandom), pio_edge};
                default: avm_readdata <= $urandom;
            endcase
        end else begin
            avm_readdata <= $urandom;
        end
    end

    // ---------------- reference model + compare ----------------
    // m_age: -2 mask write pending, -1 idle, 0..5 cycles into a service pass
    // (0 = edge read, 2 = data read, 4 = clear write, 5 = queue write).
    logic        chk_en = 1'b0;
    int          m_age = -2;
    logic [W-1:0] m_e = '0, m_l = '0;
    logic [15:0] m_t = '0, m_ts = '0;
    logic [23:0] mq[$];
    int          m_drop = 0;
    logic [7:0]  ops[$];
    int          n_mask = 0;
    int          n_clr = 0;
    logic [31:0] last_clr = '0;

    function automatic logic [35:0] bus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
        return {cs, wn, a, d};
    endfunction

    always @(negedge clk) begin
        logic [35:0] exp_bus;
        logic        pop_now, full_before;
        if (chk_en) begin
            if (reset)             exp_bus = bus(1'b0, 1'b1, 2'd0, 32'd0);
            else if (m_age == -2)  exp_bus = bus(1'b1, 1'b0, 2'd2, 32'hF);
            else if (m_age == 0)   exp_bus = bus(1'b1, 1'b1, 2'd3, 32'd0);
            else if (m_age == 2)   exp_bus = bus(1'b1, 1'b1, 2'd0, 32'd0);
            else if (m_age == 4)   exp_bus = bus(1'b1, 1'b0, 2'd3, 32'(m_e));
            else                   exp_bus = bus(1'b0, 1'b1, 2'd0, 32'd0);
            chk("bus", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, exp_bus);
            chk("evt_valid", evt_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("evt_edges", evt_edges, mq[0][7:4]);
                chk("evt_level", evt_level, mq[0][3:0]);
`ifdef PIO_EVT_TIMESTAMP_EN
                chk("evt_time", evt_time, mq[0][23:8]);
`endif
            end
            chk("drop_count", drop_count, m_drop);

            if (avm_chipselect) begin
                ops.push_back({~avm_write_n, 5'd0, avm_address});
                if (!avm_write_n && avm_address == 2'd3) begin n_clr++; last_clr = avm_writedata; end
                if (!avm_write_n && avm_address == 2'd2) n_mask++;
            end

            if (reset) begin
                mq.delete();
                m_drop = 0;
                m_age  = -2;
                m_ts   = '0;
            end else begin
                pop_now     = evt_ready && mq.size() != 0;
                full_before = mq.size() >= DEPTH;
                if (pop_now) void'(mq.pop_front());
                if (m_age == 5) begin
                    if (!full_before || pop_now) mq.push_back({m_t, m_e, m_l});
                    else if (m_drop < 255) m_drop++;
                end
                if (m_age == -2)      m_age = -1;
                else if (m_age == -1) m_age = irq ? 0 : -1;
                else if (m_age == 0)  begin m_e = pio_edge; m_t = m_ts; m_age = 1; end
                else if (m_age == 1)  m_age = (m_e == '0) ? -1 : 2;
                else if (m_age == 2)  begin m_l = pio_in; m_age = 3; end
                else if (m_age == 5)  m_age = -1;
                else                  m_age++;
                m_ts = m_ts + 16'd1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int count_ops(input logic [7:0] code);
        int n = 0;
        foreach (ops[i]) if (ops[i] == code) n++;
        return n;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int irq_i, vld_i, cnt, found, mask_before;
        logic [15:0] ta, tb;

        // reset and mask write
        @(posedge clk); #1 chk_en = 1'b1;
        step(2);
        @(negedge clk);
        chk("rst_evt_valid", evt_valid, 1'b0);
        chk("rst_drop", drop_count, 8'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("init_write", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b1, 1'b0, 2'd2, 32'hF});
        @(negedge clk);
        chk("post_init_idle", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b0, 1'b1, 2'd0, 32'd0});
        step(5);
        chk("mask_writes", n_mask, 1);

        // bit1 falling edge, level 0xD
        ops.delete();
        pio_in = 4'hD;
        irq_i = -1; vld_i = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (irq && irq_i < 0) irq_i = i;
            if (evt_valid) begin vld_i = i; break; end
        end
        chk("evt_timeout", vld_i >= 0, 1'b1);
        chk("latency", (vld_i - 1) - irq_i, 6);
        chk("single_edges", evt_edges, 4'h2);
        chk("single_level", evt_level, 4'hD);
        chk("single_clr_data", last_clr, 32'h2);
        chk("single_ops", {ops.size() == 3, ops[0], ops[1], ops[2]}, {1'b1, 8'h03, 8'h00, 8'h83});
        @(posedge clk); #1 evt_ready = 1'b1;
        step(1); evt_ready = 1'b0;

        // spurious irq
        step(2);
        ops.delete();
        irq_force = 1'b1;
        step(1); irq_force = 1'b0;
        step(10);
        chk("spur_ops", {ops.size() == 1, ops[0]}, {1'b1, 8'h03});
        chk("spur_no_evt", evt_valid, 1'b0);

        // five events into a depth-4 queue with no consumer
        ops.delete();
        for (int k = 0; k < 5; k++) begin
            pio_in[0] = 1'b0; step(12);
            pio_in[0] = 1'b1; step(2);
        end
        chk("full_drop", drop_count, 8'd1);
        chk("full_clears", count_ops(8'h83), 5);
        cnt = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (evt_valid) cnt++;
        end
        @(posedge clk); #1 evt_ready = 1'b0;
        chk("full_drained", cnt, 4);

        // reset during WT_DATA
        mask_before = n_mask;
        ops.delete();
        pio_in = 4'h9;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (ops.size() != 0 && ops[ops.size()-1] == 8'h00) begin found = 1; break; end
        end
        chk("rd_data_seen", found, 1);
        @(posedge clk); #1 reset = 1'b1;
        step(2);
        chk("abort_no_clr", count_ops(8'h83), 0);
        chk("abort_empty", evt_valid, 1'b0);
        reset = 1'b0;
        step(20);
        chk("abort_remask", n_mask, mask_before + 1);
        chk("abort_reservice", {evt_valid, evt_edges, evt_level}, {1'b1, 4'h4, 4'h9});
        evt_ready = 1'b1; step(3); evt_ready = 1'b0;

        // random traffic with a random consumer
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(2) == 0) pio_in = 4'($urandom);
            evt_ready = 1'($urandom);
            irq_force = ($urandom_range(39) == 0);
            step(1);
        end
        irq_force = 1'b0;

        // no consumer: drop counter must saturate
        evt_ready = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            pio_in = 4'($urandom);
            step(1);
        end
        chk("drop_saturate", drop_count, 8'd255);
        pio_in = 4'hF;
        step(20);
        evt_ready = 1'b1; step(20); evt_ready = 1'b0;

`ifdef PIO_EVT_TIMESTAMP_EN
        // two events 100 cycles apart straddling the counter wrap
        for (int i = 0; i < 70000 && m_ts != 16'hFFC0; i++) step(1);
        chk("ts_reach", m_ts, 16'hFFC0);
        pio_in = 4'h7; step(50);
        pio_in = 4'hF; step(50);
        pio_in = 4'h7; step(20);
        cnt = 0; ta = '0; tb = '0;
        evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (evt_valid) begin
                if (cnt == 0) ta = evt_time; else tb = evt_time;
                cnt++;
            end
        end
        @(posedge clk); #1 evt_ready = 1'b0;
        chk("ts_count", cnt, 2);
        chk("ts_diff", 16'(tb - ta), 16'd100);
        chk("ts_first", ta, 16'hFFC2);
        chk("ts_wrapped", tb, 16'h0026);
`endif

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_event_master.md
PIO_EVENT_MASTER -- requirements
Module: pio_event_master

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of PIO input bits serviced.
REQ-002 SHALL have parameter IRQ_MASK, default 4'hF: value written to the PIO interrupt-mask register after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): number of event-queue entries.
REQ-004 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: irq  in  1  PIO interrupt; avm_readdata  in  32  PIO readdata, registered, valid 1 cycle after the address is presented.
REQ-006 SHALL have ports: avm_address  out  2; avm_chipselect  out  1; avm_write_n  out  1; avm_writedata  out  32  (Avalon-MM initiator to PIO, no waitrequest).
REQ-007 SHALL have ports: evt_valid  out  1; evt_ready  in  1; evt_edges  out  WIDTH  captured edge bits; evt_level  out  WIDTH  input level.
REQ-008 SHALL have port: drop_count  out  8  number of events dropped on a full queue.

Function
REQ-009 SHALL sequence states INIT, IDLE, RD_EDGE, WT_EDGE, RD_DATA, WT_DATA, CLR, PUSH, with one cycle per state.
REQ-010 INIT SHALL drive chipselect=1, write_n=0, address=2, writedata=IRQ_MASK for one cycle, then go to IDLE; INIT SHALL be entered only from reset.
REQ-011 IDLE: irq=1 SHALL go to RD_EDGE; otherwise the block SHALL stay in IDLE with chipselect=0, write_n=1, address=0, writedata=0.
REQ-012 RD_EDGE SHALL drive chipselect=1, write_n=1, address=3; WT_EDGE SHALL latch avm_readdata[WIDTH-1:0] into the edge register.
REQ-013 If the latched edge value is 0 (spurious irq), the block SHALL return to IDLE without a clear write and without a push.
REQ-014 RD_DATA SHALL drive address=0 as a read; WT_DATA SHALL latch avm_readdata[WIDTH-1:0] into the level register.
REQ-015 CLR SHALL drive chipselect=1, write_n=0, address=3, writedata = latched edge value zero-extended, so that exactly the serviced bits are cleared.
REQ-016 PUSH SHALL write {edge, level} into the queue if it is not full; if the queue is full, the event SHALL be discarded and drop_count SHALL increment, saturating at 255. PUSH SHALL then go to IDLE.
REQ-017 Service latency SHALL be 6 cycles from the irq-sampled cycle to the queue write (IDLE->PUSH).
REQ-018 The queue SHALL be first-word-fall-through: evt_valid=1 whenever it is not empty; an entry SHALL pop on evt_valid && evt_ready.
REQ-019 A push and a pop in the same cycle on a full queue SHALL both succeed, with no drop.
REQ-020 irq remaining high after CLR, because of new or unmasked edges, SHALL start a new service pass from IDLE.
REQ-021 An edge on an already-captured bit that arrives between RD_EDGE and CLR SHALL be lost.

Reset
REQ-022 A synchronous reset SHALL force, at the next clk edge: state=INIT, chipselect=0, write_n=1, address=0, writedata=0, queue empty, evt_valid=0, drop_count=0.
REQ-023 A reset during any state SHALL abandon the pass in progress with no clear write; the PIO mask SHALL be rewritten in INIT.

Configuration
REQ-024 Macro PIO_EVT_TIMESTAMP_EN defined: the block SHALL add output evt_time [15:0], a free-running 16-bit cycle counter (reset 0, wraps) sampled in RD_EDGE and stored with each entry.
REQ-025 Macro PIO_EVT_TIMESTAMP_EN undefined: the block SHALL have no evt_time port and no counter, and queue width SHALL be 2*WIDTH.

Structure
REQ-026 Package pio_evt_pkg SHALL hold the PIO register address constants (DATA=0, MASK=2, EDGE=3) and the state enum type.
REQ-027 The queue SHALL be the sub-module pio_evt_fifo, parameterized by data width and depth, with full/empty outputs.

Verification
REQ-028 Reset release -> exactly one write, address 2, data 0xF, in the first post-reset cycle; then idle bus.
REQ-029 PIO model bit1 falling edge, level 0xD -> reads of address 3 then 0, a write to address 3 with data 0x2, then evt_edges=0x2 and evt_level=0xD; event pushed 6 cycles after irq sampled.
REQ-030 irq pulse with edge register 0 -> one read of address 3, no write, no event.
REQ-031 evt_ready=0 and 5 events with depth 4 -> 4 queued, drop_count=1, and each of the 5 events still cleared.
REQ-032 Reset asserted in WT_DATA -> no address-3 write, queue empty, INIT mask write repeated.
REQ-033 PIO_EVT_TIMESTAMP_EN defined, two events 100 cycles apart -> evt_time difference of 100, wrap verified across 0xFFFF.
